// File: rtl/vc_ctrl_pkg.sv
// Shared flit-format constants, controller state encoding and width helpers
// for the virtual-channel controller and its output-selection sub-block.
package vc_ctrl_pkg;

    localparam int DATAW    = 35;
    localparam int TYPE_MSB = 35;
    localparam int TYPE_LSB = 33;
    localparam int TYPE_W   = TYPE_MSB - TYPE_LSB + 1;

    localparam logic [TYPE_W-1:0] TYPE_NONE     = 3'b000;
    localparam logic [TYPE_W-1:0] TYPE_HEAD     = 3'b001;
    localparam logic [TYPE_W-1:0] TYPE_BODY     = 3'b010;
    localparam logic [TYPE_W-1:0] TYPE_TAIL     = 3'b011;
    localparam logic [TYPE_W-1:0] TYPE_HEADTAIL = 3'b100;

    typedef enum logic [1:0] {
        ST_RC  = 2'd0,
        ST_VSA = 2'd1,
        ST_ST  = 2'd2
    } vc_state_e;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // Field widths never collapse to zero bits, even for single-entry ranges.
    function automatic int width_of(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/vc_sel.sv
// Picks the ready/lock bit of one (port, vc) pair and the grant of one port;
// any index outside the configured range reads as zero.
module vc_sel
    import vc_ctrl_pkg::*;
#(
    parameter int NPORT = 5,
    parameter int NVCH  = 2,
    parameter int PW    = 3,
    parameter int VW    = 1
) (
    input  logic [NPORT*NVCH-1:0] irdy,
    input  logic [NPORT*NVCH-1:0] ilck,
    input  logic [NPORT-1:0]      grt,
    input  logic [PW-1:0]         port,
    input  logic [VW-1:0]         vch,
    output logic                  sel_irdy,
    output logic                  sel_ilck,
    output logic                  sel_grt
);

    // Match-and-OR selection so unmatched (out-of-range) indices give 0.
    always_comb begin
        sel_irdy = 1'b0;
        sel_ilck = 1'b0;
        sel_grt  = 1'b0;
        for (int p = 0; p < NPORT; p++) begin
            sel_grt = sel_grt | ((port == PW'(p)) && grt[p]);
            for (int v = 0; v < NVCH; v++) begin
                sel_irdy = sel_irdy | ((port == PW'(p)) && (vch == VW'(v)) && irdy[p*NVCH+v]);
                sel_ilck = sel_ilck | ((port == PW'(p)) && (vch == VW'(v)) && ilck[p*NVCH+v]);
            end
        end
    end

endmodule

// File: rtl/vc_ctrl.sv
// Per-input-VC controller: routing capture (RC), VC/switch allocation wait
// (VSA) and switch traversal (ST), with packet-length and wait watchdogs.
module vc_ctrl
    import vc_ctrl_pkg::*;
#(
    parameter int ROUTERID = 0,
    parameter int PCHID    = 0,
    parameter int VCHID    = 0,
    parameter int NPORT    = 5,
    parameter int NVCH     = 2,
    parameter int MAXLEN   = 16,
    parameter int WAITMAX  = 255
) (
    input  logic                                clk,
    input  logic                                rst_,
    input  logic [DATAW:0]                      bdata,
    input  logic                                bvalid,
    input  logic [width_of(NPORT)-1:0]          port,
    input  logic [width_of(NVCH)-1:0]           ovch,
    input  logic [NPORT*NVCH-1:0]               irdy,
    input  logic [NPORT*NVCH-1:0]               ilck,
    input  logic [NPORT-1:0]                    grt,
    output logic                                req,
    output logic                                send,
    output logic                                olck,
    output logic [width_of(MAXLEN+1)-1:0]       flitcnt,
    output logic                                err_len,
    output logic                                err_wait
);

    localparam int PW = width_of(NPORT);
    localparam int VW = width_of(NVCH);
    localparam int CW = width_of(MAXLEN + 1);
    localparam int WW = width_of(WAITMAX + 1);

    vc_state_e       state_r, state_s;
    logic            req_r, req_s;
    logic [CW-1:0]   flitcnt_r, flitcnt_s;
    logic [WW-1:0]   waitcnt_r, waitcnt_s;
    logic [PW-1:0]   lport_r, lport_s;
    logic [VW-1:0]   lovch_r, lovch_s;
    logic            err_len_r, err_len_s;
    logic            err_wait_r, err_wait_s;

    logic            sel_irdy_s;
    logic            sel_ilck_s;
    logic            sel_grt_s;
    logic [TYPE_W-1:0] ftype_s;
    logic            is_head_s;
    logic            is_tail_s;
    logic            send_s;
    logic            unused_s;

    vc_sel #(
        .NPORT (NPORT),
        .NVCH  (NVCH),
        .PW    (PW),
        .VW    (VW)
    ) u_sel (
        .irdy     (irdy),
        .ilck     (ilck),
        .grt      (grt),
        .port     (lport_r),
        .vch      (lovch_r),
        .sel_irdy (sel_irdy_s),
        .sel_ilck (sel_ilck_s),
        .sel_grt  (sel_grt_s)
    );

    assign ftype_s   = bdata[TYPE_MSB:TYPE_LSB];
    assign is_head_s = (ftype_s == TYPE_HEAD) || (ftype_s == TYPE_HEADTAIL);
    assign is_tail_s = (ftype_s == TYPE_TAIL) || (ftype_s == TYPE_HEADTAIL);
    assign send_s    = (state_r == ST_ST) && bvalid && sel_irdy_s && sel_grt_s;
    // Payload bits and informational identifiers are not consumed here.
    assign unused_s  = ^{bdata[TYPE_LSB-1:0], 32'(ROUTERID), 32'(PCHID), 32'(VCHID)};

    // Next-state, request and counter decisions.
    always_comb begin
        state_s    = state_r;
        req_s      = req_r;
        flitcnt_s  = flitcnt_r;
        waitcnt_s  = waitcnt_r;
        lport_s    = lport_r;
        lovch_s    = lovch_r;
        err_len_s  = 1'b0;
        err_wait_s = 1'b0;
        case (state_r)
            ST_RC: begin
                flitcnt_s = {CW{1'b0}};
                waitcnt_s = {WW{1'b0}};
                if (bvalid && is_head_s) begin
                    lport_s = port;
                    lovch_s = ovch;
                    req_s   = 1'b1;
                    state_s = ST_VSA;
                end else begin
                    req_s   = 1'b0;
                    state_s = ST_RC;
                end
            end
            ST_VSA: begin
                if (sel_irdy_s && sel_grt_s) begin
                    state_s   = ST_ST;
                    req_s     = 1'b1;
                    waitcnt_s = {WW{1'b0}};
                end else begin
                    req_s = !sel_ilck_s;
                    // The counter never holds WAITMAX: it wraps on the edge that reaches it.
                    if (waitcnt_r == WW'(WAITMAX - 1)) begin
                        err_wait_s = 1'b1;
                        waitcnt_s  = {WW{1'b0}};
                    end else begin
                        waitcnt_s  = waitcnt_r + WW'(1);
                    end
                end
            end
            ST_ST: begin
                if (send_s) begin
                    if (is_tail_s) begin
                        state_s   = ST_RC;
                        req_s     = 1'b0;
                        flitcnt_s = {CW{1'b0}};
                    end else if ((flitcnt_r + CW'(1)) == CW'(MAXLEN)) begin
                        err_len_s = 1'b1;
                        state_s   = ST_RC;
                        req_s     = 1'b0;
                        flitcnt_s = {CW{1'b0}};
                    end else begin
                        req_s     = 1'b1;
                        flitcnt_s = flitcnt_r + CW'(1);
                    end
                end else begin
                    req_s = 1'b1;
                end
            end
            default: begin
                state_s   = ST_RC;
                req_s     = 1'b0;
                flitcnt_s = {CW{1'b0}};
                waitcnt_s = {WW{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_r    <= ST_RC;
            req_r      <= 1'b0;
            flitcnt_r  <= {CW{1'b0}};
            waitcnt_r  <= {WW{1'b0}};
            lport_r    <= {PW{1'b0}};
            lovch_r    <= {VW{1'b0}};
            err_len_r  <= 1'b0;
            err_wait_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            req_r      <= req_s;
            flitcnt_r  <= flitcnt_s;
            waitcnt_r  <= waitcnt_s;
            lport_r    <= lport_s;
            lovch_r    <= lovch_s;
            err_len_r  <= err_len_s;
            err_wait_r <= err_wait_s;
        end
    end

    assign req      = req_r;
    assign send     = send_s;
    assign olck     = (state_r != ST_RC);
    assign flitcnt  = flitcnt_r;
    assign err_len  = err_len_r;
    assign err_wait = err_wait_r;

endmodule

// File: tb/tb_vc_ctrl.sv
// Directed bench for vc_ctrl: instance a (WAITMAX=4, MAXLEN=16) and
// instance b (MAXLEN=3) share stimulus; each scenario checks one of them.
module tb_vc_ctrl;
    import vc_ctrl_pkg::*;

    logic          clk;
    logic          rst_;
    logic [DATAW:0] bdata;
    logic          bvalid;
    logic [2:0]    port;
    logic [0:0]    ovch;
    logic [9:0]    irdy;
    logic [9:0]    ilck;
    logic [4:0]    grt;

    logic          req_a, send_a, olck_a, err_len_a, err_wait_a;
    logic [4:0]    flitcnt_a;
    logic          req_b, send_b, olck_b, err_len_b, err_wait_b;
    logic [1:0]    flitcnt_b;

    int nvec;
    int nerr;

    vc_ctrl #(
        .ROUTERID (1), .PCHID (2), .VCHID (0),
        .NPORT (5), .NVCH (2), .MAXLEN (16), .WAITMAX (4)
    ) u_dut_a (
        .clk (clk), .rst_ (rst_), .bdata (bdata), .bvalid (bvalid),
        .port (port), .ovch (ovch), .irdy (irdy), .ilck (ilck), .grt (grt),
        .req (req_a), .send (send_a), .olck (olck_a), .flitcnt (flitcnt_a),
        .err_len (err_len_a), .err_wait (err_wait_a)
    );

    vc_ctrl #(
        .NPORT (5), .NVCH (2), .MAXLEN (3), .WAITMAX (255)
    ) u_dut_b (
        .clk (clk), .rst_ (rst_), .bdata (bdata), .bvalid (bvalid),
        .port (port), .ovch (ovch), .irdy (irdy), .ilck (ilck), .grt (grt),
        .req (req_b), .send (send_b), .olck (olck_b), .flitcnt (flitcnt_b),
        .err_len (err_len_b), .err_wait (err_wait_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATAW:0] flit(input logic [TYPE_W-1:0] t);
        logic [DATAW:0] f;
        f = '0;
        f[TYPE_MSB:TYPE_LSB] = t;
        f[7:0] = 8'hA5;
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec = nvec + 1;
        assert (obs === exp) else begin
            nerr = nerr + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst_ = 1'b0; bvalid = 1'b0; bdata = flit(TYPE_NONE);
        port = 3'd0; ovch = 1'b0; irdy = 10'd0; ilck = 10'd0; grt = 5'd0;
        tick(); tick();
        chk("rst_req", 32'(req_a), 32'd0);
        chk("rst_olck", 32'(olck_a), 32'd0);
        chk("rst_flitcnt", 32'(flitcnt_a), 32'd0);
        chk("rst_err_len", 32'(err_len_a), 32'd0);
        chk("rst_err_wait", 32'(err_wait_a), 32'd0);
        chk("rst_send", 32'(send_a), 32'd0);
        rst_ = 1'b1;

        // Single-flit packet to port 2 / vc 1 (bit 5), port/ovch change after capture
        bdata = flit(TYPE_HEADTAIL); bvalid = 1'b1; port = 3'd2; ovch = 1'b1;
        irdy = 10'b00_0010_0000; grt = 5'b00100;
        #1 chk("ht_rc_send", 32'(send_a), 32'd0);
        tick();
        chk("ht_vsa_olck", 32'(olck_a), 32'd1);
        chk("ht_vsa_req", 32'(req_a), 32'd1);
        chk("ht_vsa_send", 32'(send_a), 32'd0);
        port = 3'd0; ovch = 1'b0;
        tick();
        chk("ht_st_olck", 32'(olck_a), 32'd1);
        chk("ht_st_send", 32'(send_a), 32'd1);
        tick();
        chk("ht_done_olck", 32'(olck_a), 32'd0);
        chk("ht_done_req", 32'(req_a), 32'd0);
        chk("ht_done_flitcnt", 32'(flitcnt_a), 32'd0);
        chk("ht_done_send", 32'(send_a), 32'd0);
        bvalid = 1'b0;
        tick();

        // Four-flit packet to port 0 / vc 0 with a three-cycle downstream stall
        bdata = flit(TYPE_HEAD); bvalid = 1'b1; port = 3'd0; ovch = 1'b0;
        irdy = 10'b00_0000_0001; grt = 5'b00001;
        tick();
        tick();
        chk("pk_head_send", 32'(send_a), 32'd1);
        chk("pk_head_cnt", 32'(flitcnt_a), 32'd0);
        tick();
        chk("pk_cnt1", 32'(flitcnt_a), 32'd1);
        bdata = flit(TYPE_BODY);
        #1 chk("pk_body1_send", 32'(send_a), 32'd1);
        tick();
        chk("pk_cnt2", 32'(flitcnt_a), 32'd2);
        irdy = 10'd0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("pk_stall_send", 32'(send_a), 32'd0);
            tick();
            chk("pk_stall_cnt", 32'(flitcnt_a), 32'd2);
            chk("pk_stall_req", 32'(req_a), 32'd1);
        end
        irdy = 10'b00_0000_0001;
        #1 chk("pk_body2_send", 32'(send_a), 32'd1);
        tick();
        chk("pk_cnt3", 32'(flitcnt_a), 32'd3);
        bdata = flit(TYPE_TAIL);
        #1 chk("pk_tail_send", 32'(send_a), 32'd1);
        tick();
        chk("pk_done_req", 32'(req_a), 32'd0);
        chk("pk_done_cnt", 32'(flitcnt_a), 32'd0);
        chk("pk_done_olck", 32'(olck_a), 32'd0);
        bvalid = 1'b0;
        tick();

        // Downstream VC locked (port 1 / vc 0 -> bit 2): request withdrawn
        bdata = flit(TYPE_HEAD); bvalid = 1'b1; port = 3'd1; ovch = 1'b0;
        irdy = 10'd0; grt = 5'd0; ilck = 10'b00_0000_0100;
        tick();
        chk("lk_enter_req", 32'(req_a), 32'd1);
        tick();
        chk("lk_req0_a", 32'(req_a), 32'd0);
        tick();
        chk("lk_req0_b", 32'(req_a), 32'd0);
        ilck = 10'd0;
        tick();
        chk("lk_req1", 32'(req_a), 32'd1);
        chk("lk_olck", 32'(olck_a), 32'd1);
        rst_ = 1'b0;
        tick();
        chk("lk_rst_olck", 32'(olck_a), 32'd0);
        rst_ = 1'b1;

        // Wait watchdog (WAITMAX=4): pulse registered off the 4th and 8th waiting cycles
        bdata = flit(TYPE_HEAD); bvalid = 1'b1; port = 3'd3; ovch = 1'b1;
        irdy = 10'b11_1111_1111; grt = 5'd0; ilck = 10'd0;
        tick();
        for (int k = 1; k <= 9; k++) begin
            chk("wt_err_wait", 32'(err_wait_a), ((k == 5) || (k == 9)) ? 32'd1 : 32'd0);
            chk("wt_olck", 32'(olck_a), 32'd1);
            chk("wt_req", 32'(req_a), 32'd1);
            tick();
        end
        rst_ = 1'b0;
        tick();
        rst_ = 1'b1;

        // Length watchdog on instance b (MAXLEN=3): fourth flit never sent
        bdata = flit(TYPE_HEAD); bvalid = 1'b1; port = 3'd0; ovch = 1'b0;
        irdy = 10'b11_1111_1111; grt = 5'b11111;
        tick();
        tick();
        chk("ln_head_send", 32'(send_b), 32'd1);
        tick();
        bdata = flit(TYPE_BODY);
        #1 chk("ln_body1_send", 32'(send_b), 32'd1);
        tick();
        chk("ln_cnt2", 32'(flitcnt_b), 32'd2);
        chk("ln_pre_err", 32'(err_len_b), 32'd0);
        #1 chk("ln_body2_send", 32'(send_b), 32'd1);
        tick();
        chk("ln_err_len", 32'(err_len_b), 32'd1);
        chk("ln_olck", 32'(olck_b), 32'd0);
        chk("ln_cnt0", 32'(flitcnt_b), 32'd0);
        chk("ln_req", 32'(req_b), 32'd0);
        #1 chk("ln_body3_send", 32'(send_b), 32'd0);
        tick();
        chk("ln_err_len_drop", 32'(err_len_b), 32'd0);
        chk("ln_rc_hold", 32'(olck_b), 32'd0);
        rst_ = 1'b0;
        tick();
        rst_ = 1'b1;

        // Reset mid-packet after two sends to port 4 / vc 1 (top bit 9)
        bdata = flit(TYPE_HEAD); bvalid = 1'b1; port = 3'd4; ovch = 1'b1;
        irdy = 10'b10_0000_0000; grt = 5'b10000;
        tick();
        tick();
        chk("mr_head_send", 32'(send_a), 32'd1);
        tick();
        bdata = flit(TYPE_BODY);
        tick();
        chk("mr_cnt2", 32'(flitcnt_a), 32'd2);
        rst_ = 1'b0;
        tick();
        chk("mr_olck", 32'(olck_a), 32'd0);
        chk("mr_cnt", 32'(flitcnt_a), 32'd0);
        chk("mr_req", 32'(req_a), 32'd0);
        chk("mr_err_len", 32'(err_len_a), 32'd0);
        rst_ = 1'b1; bvalid = 1'b0;
        tick();
        chk("mr_after_err_len", 32'(err_len_a), 32'd0);
        chk("mr_after_err_wait", 32'(err_wait_a), 32'd0);
        chk("mr_after_olck", 32'(olck_a), 32'd0);

        // Out-of-range port 5: all selects read 0 -> stuck in VSA, request held
        bdata = flit(TYPE_HEAD); bvalid = 1'b1; port = 3'd5; ovch = 1'b0;
        irdy = 10'b11_1111_1111; grt = 5'b11111; ilck = 10'b11_1111_1111;
        tick();
        tick();
        chk("oor_olck", 32'(olck_a), 32'd1);
        chk("oor_req", 32'(req_a), 32'd1);
        tick();
        chk("oor_send", 32'(send_a), 32'd0);
        chk("oor_stay", 32'(olck_a), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/vc_ctrl.md
VC_CTRL -- requirements
Module: vc_ctrl

Interface
REQ-001 SHALL have parameter ROUTERID, default 0, router identifier (informational).
REQ-002 SHALL have parameter PCHID, default 0, physical input channel index (informational).
REQ-003 SHALL have parameter VCHID, default 0, virtual channel index (informational).
REQ-004 SHALL have parameter NPORT, default 5, number of output ports.
REQ-005 SHALL have parameter NVCH, default 2, VCs per output port.
REQ-006 SHALL have parameter MAXLEN, default 16, max flits per packet including head.
REQ-007 SHALL have parameter WAITMAX, default 255, VSA wait cycles before err_wait.
REQ-008 SHALL derive PW = clog2(NPORT), VW = clog2(NVCH), CW = clog2(MAXLEN+1); each is at least 1.
REQ-009 SHALL have clk  input  1  single clock; all logic on its rising edge.
REQ-010 SHALL have rst_  input  1  reset, synchronous, active-low.
REQ-011 SHALL have bdata  input  `DATAW+1  buffer-head flit; type field is bdata[`TYPE_MSB:`TYPE_LSB].
REQ-012 SHALL have bvalid  input  1  bdata holds a valid flit.
REQ-013 SHALL have port  input  PW  routed output port for the head flit.
REQ-014 SHALL have ovch  input  VW  allocated output VC for the head flit.
REQ-015 SHALL have irdy  input  NPORT*NVCH  downstream VC ready; bit p*NVCH+v.
REQ-016 SHALL have ilck  input  NPORT*NVCH  downstream VC locked by another input VC; same indexing.
REQ-017 SHALL have grt  input  NPORT  switch grant per output port.
REQ-018 SHALL have req  output  1  switch request, registered.
REQ-019 SHALL have send  output  1  flit transfers this cycle, combinational.
REQ-020 SHALL have olck  output  1  this VC holds an output VC.
REQ-021 SHALL have flitcnt  output  CW  flits sent in the current packet.
REQ-022 SHALL have err_len  output  1  one-cycle pulse, packet exceeded MAXLEN.
REQ-023 SHALL have err_wait  output  1  one-cycle pulse, VSA waited WAITMAX cycles.

Function
REQ-024 SHALL implement states RC, VSA, ST.
REQ-025 SHALL drive olck = (state != RC).
REQ-026 In RC, when bvalid=1 and type is HEAD or HEADTAIL: latch port/ovch into lport/lovch, set req=1, go to VSA; otherwise hold with req=0.
REQ-027 SHALL use only latched lport/lovch after RC; changes to port/ovch during VSA/ST are ignored.
REQ-028 SHALL form sel_irdy = irdy[lport*NVCH+lovch], sel_ilck = ilck[same index], sel_grt = grt[lport]; any out-of-range index yields 0.
REQ-029 In VSA, priority order: (a) sel_irdy & sel_grt -> go to ST, req=1, clear wait counter; (b) else sel_ilck -> req=0; (c) else req=1.
REQ-030 In VSA, the wait counter SHALL increment each cycle that case (a) does not occur; on reaching WAITMAX, err_wait pulses for one cycle, counter clears to 0, state stays VSA.
REQ-031 SHALL drive send = (state==ST) & bvalid & sel_irdy & sel_grt; send is never asserted outside ST.
REQ-032 On each send cycle, flitcnt SHALL increment by 1.
REQ-033 On a send cycle whose flit type is TAIL or HEADTAIL: go to RC, req=0, flitcnt=0.
REQ-034 On a non-tail send cycle where flitcnt+1 == MAXLEN: err_len pulses, go to RC, req=0, flitcnt=0 (packet truncated).
REQ-035 In ST with no send: hold state, flitcnt and req=1.
REQ-036 Leaving ST always inserts exactly one RC cycle before the next head is accepted.

Reset
REQ-037 With rst_=0 at a clk edge: state=RC, req=0, flitcnt=0, wait counter=0, lport=0, lovch=0, err_len=0, err_wait=0; send=0 and olck=0 follow.
REQ-038 Reset asserted mid-packet SHALL abandon the packet immediately and emit no error pulse.

Structure
REQ-039 `DATAW, `TYPE_MSB/`TYPE_LSB, TYPE_HEAD/BODY/TAIL/HEADTAIL, `Enable/`Disable/`Enable_ and the clog2 function SHALL reside in shared defines.v.
REQ-040 The indexed irdy/ilck/grt selection SHALL be one sub-module, vc_sel, reusable by the output allocator.

Verification
REQ-041 HEADTAIL, port=2, ovch=1, irdy[5]=grt[2]=1 -> VSA next cycle, ST the cycle after, send=1 for one cycle, back to RC, flitcnt=0.
REQ-042 HEAD+2 BODY+TAIL to port 0 with irdy[0] low for 3 cycles mid-packet -> send=0 during stall, flitcnt holds, after the tail send req=0.
REQ-043 In VSA with ilck[lport*NVCH+lovch]=1, grt=0 -> req=0; after ilck drops -> req=1 next cycle.
REQ-044 WAITMAX=4, grt held 0 -> err_wait pulses at the 4th and 8th VSA cycle; state stays VSA.
REQ-045 MAXLEN=3, HEAD+BODY+BODY+BODY -> err_len on the 3rd send, state RC, 4th flit not sent.
REQ-046 rst_=0 for one cycle in ST after 2 sends -> state RC, flitcnt=0, req=0, no err pulse.
